mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have port: clk  input  1  clock; all state updates occur on its rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: addr  input  32  byte address from the EX/MEM stage ALU result.
REQ-004 SHALL have port: wdata  input  32  store data, already forwarded, right-aligned.
REQ-005 SHALL have port: mem_op  input  4  access type; encodings are in REQ-041.
REQ-006 SHALL have port: flush  input  1  exception or interrupt taken this cycle; suppresses the store.
REQ-007 SHALL have port: rdata  output  32  load result after extension, to MEMWB RD_M.
REQ-008 SHALL have port: exc_code  output  5  0 = none, 4 = AdEL, 5 = AdES.
REQ-009 SHALL have port: pr_addr  output  32  bridge address, equal to {addr[31:2],2'b00}.
REQ-010 SHALL have port: pr_wdata  output  32  bridge store data, equal to wdata.
REQ-011 SHALL have port: pr_we  output  1  bridge write strobe.
REQ-012 SHALL have port: pr_rdata  input  32  bridge read data, to be extended like DM data.

Function
REQ-013 SHALL contain the data memory: 3072 x 32-bit words, byte range 0x0000_0000-0x0000_2FFF.
REQ-014 SHALL treat 0x0000_7F00-0x0000_7F0B (TC0) and 0x0000_7F10-0x0000_7F1B (TC1) as device space.
REQ-015 SHALL read combinationally, so rdata is valid in the same cycle as addr and mem_op.
REQ-016 SHALL take the load word from DM in DM space and from pr_rdata in device space.
REQ-017 LB/LH SHALL sign-extend and LBU/LHU SHALL zero-extend the lane selected by addr[1:0] (byte) or addr[1] (half).
REQ-018 SW SHALL write all 4 bytes.
REQ-019 SH SHALL write bytes {addr[1],1}..{addr[1],0} with wdata[15:0]; all other bytes SHALL be unchanged.
REQ-020 SB SHALL write byte addr[1:0] with wdata[7:0]; all other bytes SHALL be unchanged.
REQ-021 The DM write SHALL commit at posedge clk only when: the op is a store, the address is in DM space, exc_code==0, and flush==0.
REQ-022 pr_we SHALL be 1 only when: op==SW, the address is in device space, exc_code==0, and flush==0.
REQ-023 SHALL raise AdEL on a load with a misaligned address (LW: addr[1:0]!=0; LH/LHU: addr[0]!=0).
REQ-024 SHALL raise AdEL on a load outside DM and device space.
REQ-025 SHALL raise AdEL on a half or byte load in device space.
REQ-026 SHALL raise AdES under the same misalignment and range rules for stores.
REQ-027 SHALL raise AdES on a half or byte store to device space.
REQ-028 SHALL raise AdES on a store to timer COUNT (offset 0x8).
REQ-029 When more than one fault condition applies, SHALL report a single code: AdEL for loads, AdES for stores.
REQ-030 With mem_op==NONE: exc_code SHALL be 0, pr_we SHALL be 0, and rdata SHALL be 0.
REQ-031 When an exception is raised, rdata is don't-care and no state SHALL change.
REQ-032 flush asserted with a valid store SHALL suppress the write; exc_code still reflects the address check.
REQ-033 Back-to-back store then load to the same word SHALL return the newly stored value in the following cycle.
REQ-034 Address bits above 0x2FFF within the word index SHALL NOT wrap into DM; they SHALL fault instead.

Reset
REQ-035 On reset, SHALL clear every DM word to 0x0000_0000 at the next posedge.
REQ-036 A store presented in the reset cycle SHALL be discarded.
REQ-037 pr_we SHALL be forced to 0 while reset==1.
REQ-038 Combinational outputs SHALL follow their inputs during reset, with pr_we forced to 0.

Structure
REQ-039 The shared package macrodefine.v SHALL hold the mem_op encodings.
REQ-040 The shared package macrodefine.v SHALL also hold: DM_WORDS = 3072, the TC0/TC1 base and end addresses, and EXC_ADEL = 4 / EXC_ADES = 5.
REQ-041 mem_op encodings SHALL be: NONE=0, LW=1, LH=2, LHU=3, LB=4, LBU=5, SW=6, SH=7, SB=8.
REQ-042 SHALL instantiate one sub-module, load_ext, for the combinational lane select and extension (inputs: word, addr[1:0], mem_op).

Verification
REQ-043 Scenario 1: SW 0x1234_5678 @0x10, then LW @0x10 -> rdata = 0x1234_5678, exc_code = 0.
REQ-044 Scenario 2: SB 0xAB @0x11, then LB @0x11 -> rdata = 0xFFFF_FFAB; LBU @0x11 -> rdata = 0x0000_00AB; LW @0x10 -> rdata = 0x1234_AB78.
REQ-045 Scenario 3: SH 0x8001 @0x12, then LH @0x12 -> rdata = 0xFFFF_8001; LHU @0x12 -> rdata = 0x0000_8001; LW @0x10 -> rdata = 0x8001_AB78.
REQ-046 Scenario 4: LW @0x3 -> exc_code = 4; SH @0x1 -> exc_code = 5 and memory unchanged; LW @0x3000 -> exc_code = 4.
REQ-047 Scenario 5: SW @0x7F04 -> pr_we = 1, pr_addr = 0x7F04; SW @0x7F08 -> exc_code = 5, pr_we = 0; LB @0x7F10 -> exc_code = 4.
REQ-048 Scenario 6: SW 0xFFFF_FFFF @0x20 with flush = 1, then LW @0x20 -> rdata = 0.
REQ-049 Scenario 6 (cont.): assert reset after writes, then LW @0x10 -> rdata = 0.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg: shared access-type encodings, memory map and exception codes
package mem_access_unit_pkg;

    typedef enum logic [3:0] {
        OP_NONE = 4'd0,
        OP_LW   = 4'd1,
        OP_LH   = 4'd2,
        OP_LHU  = 4'd3,
        OP_LB   = 4'd4,
        OP_LBU  = 4'd5,
        OP_SW   = 4'd6,
        OP_SH   = 4'd7,
        OP_SB   = 4'd8
    } mem_op_e;

    localparam int          DM_WORDS = 3072;
    localparam logic [31:0] DM_END   = 32'h0000_2FFF;
    localparam logic [31:0] TC0_BASE = 32'h0000_7F00;
    localparam logic [31:0] TC0_END  = 32'h0000_7F0B;
    localparam logic [31:0] TC1_BASE = 32'h0000_7F10;
    localparam logic [31:0] TC1_END  = 32'h0000_7F1B;
    localparam logic [4:0]  EXC_NONE = 5'd0;
    localparam logic [4:0]  EXC_ADEL = 5'd4;
    localparam logic [4:0]  EXC_ADES = 5'd5;

endpackage

// File: rtl/mem_access_unit_load_ext.sv
// load_ext: selects the loaded lane of a word and sign/zero-extends it
//   word   in  32  raw word from DM or the device bridge
//   off    in  2   addr[1:0], byte offset within the word
//   mem_op in  4   access type; non-load ops yield 0
//   result out 32  extended load value
module load_ext
    import mem_access_unit_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  off,
    input  logic [3:0]  mem_op,
    output logic [31:0] result
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = word[{off, 3'b000} +: 8];
        lane_h = off[1] ? word[31:16] : word[15:0];
        result = mem_op == OP_LW  ? word :
                 mem_op == OP_LH  ? {{16{lane_h[15]}}, lane_h} :
                 mem_op == OP_LHU ? {16'h0000, lane_h} :
                 mem_op == OP_LB  ? {{24{lane_b[7]}}, lane_b} :
                 mem_op == OP_LBU ? {24'h00_0000, lane_b} : 32'h0000_0000;
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage data memory, device bridge and address-exception check
//   clk      in  1   rising-edge clock
//   reset    in  1   synchronous active-high reset; clears DM, blocks pr_we
//   addr     in  32  byte address
//   wdata    in  32  right-aligned store data
//   mem_op   in  4   access type
//   flush    in  1   suppresses any store this cycle
//   rdata    out 32  extended load result (combinational)
//   exc_code out 5   0 none, 4 AdEL, 5 AdES
//   pr_addr  out 32  word-aligned bridge address
//   pr_wdata out 32  bridge store data
//   pr_we    out 1   bridge write strobe
//   pr_rdata in  32  bridge read data
module mem_access_unit
    import mem_access_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  mem_op,
    input  logic        flush,
    output logic [31:0] rdata,
    output logic [4:0]  exc_code,
    output logic [31:0] pr_addr,
    output logic [31:0] pr_wdata,
    output logic        pr_we,
    input  logic [31:0] pr_rdata
);

    logic [31:0] dm [DM_WORDS];
    logic        is_load, is_store, is_word, is_half;
    logic        in_dm, in_dev, misalign, bad, dm_we;
    logic [11:0] idx;
    logic [3:0]  be;
    logic [31:0] wlane, dm_word, ld_word;

    always_comb begin
        is_load  = mem_op >= OP_LW && mem_op <= OP_LBU;
        is_store = mem_op >= OP_SW && mem_op <= OP_SB;
        is_word  = mem_op == OP_LW || mem_op == OP_SW;
        is_half  = mem_op == OP_LH || mem_op == OP_LHU || mem_op == OP_SH;
        // Full-address compare so high bits never alias back into DM
        in_dm    = addr <= DM_END;
        in_dev   = (addr >= TC0_BASE && addr <= TC0_END) || (addr >= TC1_BASE && addr <= TC1_END);
        misalign = is_word ? addr[1:0] != 2'b00 : is_half ? addr[0] : 1'b0;
        // Timer COUNT sits at word offset 0x8 of either timer and is read-only
        bad      = (is_load || is_store) && (misalign || !(in_dm || in_dev) ||
                   (in_dev && !is_word) || (is_store && in_dev && addr[3:2] == 2'b10));
        exc_code = !bad ? EXC_NONE : is_load ? EXC_ADEL : EXC_ADES;
        idx      = addr[13:2];
        be       = mem_op == OP_SW ? 4'b1111 :
                   mem_op == OP_SH ? (addr[1] ? 4'b1100 : 4'b0011) :
                   4'b0001 << addr[1:0];
        wlane    = mem_op == OP_SW ? wdata :
                   mem_op == OP_SH ? {2{wdata[15:0]}} : {4{wdata[7:0]}};
        dm_we    = is_store && in_dm && !bad && !flush;
        dm_word  = in_dm ? dm[idx] : 32'h0000_0000;
        ld_word  = in_dev ? pr_rdata : dm_word;
        pr_we    = !reset && mem_op == OP_SW && in_dev && !bad && !flush;
        pr_addr  = {addr[31:2], 2'b00};
        pr_wdata = wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DM_WORDS; i++) dm[i] <= 32'h0000_0000;
        end else if (dm_we) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) dm[idx][8*b +: 8] <= wlane[8*b +: 8];
        end
    end

    load_ext u_load_ext (
        .word   (ld_word),
        .off    (addr[1:0]),
        .mem_op (mem_op),
        .result (rdata)
    );

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed self-checking bench for mem_access_unit
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr, wdata, rdata, pr_addr, pr_wdata, pr_rdata;
    logic [3:0]  mem_op;
    logic        flush, pr_we;
    logic [4:0]  exc_code;
    int          passed = 0;
    int          total = 0;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk      (clk),
        .reset    (reset),
        .addr     (addr),
        .wdata    (wdata),
        .mem_op   (mem_op),
        .flush    (flush),
        .rdata    (rdata),
        .exc_code (exc_code),
        .pr_addr  (pr_addr),
        .pr_wdata (pr_wdata),
        .pr_we    (pr_we),
        .pr_rdata (pr_rdata)
    );

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] d, input logic f);
        mem_op = op;
        addr   = a;
        wdata  = d;
        flush  = f;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        mem_op = OP_NONE;
        flush  = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        pr_rdata = 32'h0;
        drive(OP_SW, 32'h7F04, 32'h5555_AAAA, 1'b0);
        total++; if (pr_we !== 1'b0) $display("FAIL reset_pr_we got=%b exp=0", pr_we); else passed++;
        drive(OP_SW, 32'h10, 32'hDEAD_BEEF, 1'b0);
        tick();
        reset = 1'b0;
        drive(OP_LW, 32'h10, 32'h0, 1'b0);
        total++; if (rdata !== 32'h0) $display("FAIL reset_store_discard rdata=%h exp=%h", rdata, 32'h0); else passed++;
        drive(OP_NONE, 32'h10, 32'h0, 1'b0);
        total++; if ({rdata, exc_code, pr_we} !== 38'h0) $display("FAIL none_outputs rdata=%h exc=%0d we=%b exp=0", rdata, exc_code, pr_we); else passed++;
    endtask

    task automatic test_word();
        drive(OP_SW, 32'h10, 32'h1234_5678, 1'b0);
        tick();
        drive(OP_LW, 32'h10, 32'h0, 1'b0);
        total++; if (rdata !== 32'h1234_5678) $display("FAIL lw_word rdata=%h exp=%h", rdata, 32'h1234_5678); else passed++;
        total++; if (exc_code !== 5'd0) $display("FAIL lw_word_exc got=%0d exp=0", exc_code); else passed++;
    endtask

    task automatic test_byte();
        drive(OP_SB, 32'h11, 32'h0000_00AB, 1'b0);
        tick();
        drive(OP_LB, 32'h11, 32'h0, 1'b0);
        total++; if (rdata !== 32'hFFFF_FFAB) $display("FAIL lb rdata=%h exp=%h", rdata, 32'hFFFF_FFAB); else passed++;
        drive(OP_LBU, 32'h11, 32'h0, 1'b0);
        total++; if (rdata !== 32'h0000_00AB) $display("FAIL lbu rdata=%h exp=%h", rdata, 32'h0000_00AB); else passed++;
        drive(OP_LW, 32'h10, 32'h0, 1'b0);
        total++; if (rdata !== 32'h1234_AB78) $display("FAIL sb_merge rdata=%h exp=%h", rdata, 32'h1234_AB78); else passed++;
        drive(OP_LB, 32'h10, 32'h0, 1'b0);
        total++; if (rdata !== 32'h0000_0078) $display("FAIL lb_lane0 rdata=%h exp=%h", rdata, 32'h0000_0078); else passed++;
    endtask

    task automatic test_half();
        drive(OP_SH, 32'h12, 32'hFFFF_8001, 1'b0);
        tick();
        drive(OP_LH, 32'h12, 32'h0, 1'b0);
        total++; if (rdata !== 32'hFFFF_8001) $display("FAIL lh rdata=%h exp=%h", rdata, 32'hFFFF_8001); else passed++;
        drive(OP_LHU, 32'h12, 32'h0, 1'b0);
        total++; if (rdata !== 32'h0000_8001) $display("FAIL lhu rdata=%h exp=%h", rdata, 32'h0000_8001); else passed++;
        drive(OP_LW, 32'h10, 32'h0, 1'b0);
        total++; if (rdata !== 32'h8001_AB78) $display("FAIL sh_merge rdata=%h exp=%h", rdata, 32'h8001_AB78); else passed++;
        drive(OP_LH, 32'h10, 32'h0, 1'b0);
        total++; if (rdata !== 32'hFFFF_AB78) $display("FAIL lh_low rdata=%h exp=%h", rdata, 32'hFFFF_AB78); else passed++;
    endtask

    task automatic test_faults();
        drive(OP_LW, 32'h3, 32'h0, 1'b0);
        total++; if (exc_code !== 5'd4) $display("FAIL lw_misalign exc=%0d exp=4", exc_code); else passed++;
        drive(OP_LH, 32'h11, 32'h0, 1'b0);
        total++; if (exc_code !== 5'd4) $display("FAIL lh_misalign exc=%0d exp=4", exc_code); else passed++;
        drive(OP_SH, 32'h1, 32'h0000_BEEF, 1'b0);
        total++; if (exc_code !== 5'd5) $display("FAIL sh_misalign exc=%0d exp=5", exc_code); else passed++;
        tick();
        drive(OP_LW, 32'h0, 32'h0, 1'b0);
        total++; if (rdata !== 32'h0) $display("FAIL sh_fault_nowrite rdata=%h exp=%h", rdata, 32'h0); else passed++;
        drive(OP_LW, 32'h3000, 32'h0, 1'b0);
        total++; if (exc_code !== 5'd4) $display("FAIL lw_range exc=%0d exp=4", exc_code); else passed++;
        drive(OP_LW, 32'h2FFC, 32'h0, 1'b0);
        total++; if (exc_code !== 5'd0) $display("FAIL lw_last_word exc=%0d exp=0", exc_code); else passed++;
        drive(OP_SW, 32'h4010, 32'hCCCC_CCCC, 1'b0);
        total++; if (exc_code !== 5'd5) $display("FAIL sw_alias exc=%0d exp=5", exc_code); else passed++;
        tick();
        drive(OP_LW, 32'h10, 32'h0, 1'b0);
        total++; if (rdata !== 32'h8001_AB78) $display("FAIL sw_alias_nowrite rdata=%h exp=%h", rdata, 32'h8001_AB78); else passed++;
    endtask

    task automatic test_device();
        drive(OP_SW, 32'h7F04, 32'h0000_00C8, 1'b0);
        total++; if (pr_we !== 1'b1) $display("FAIL dev_sw_we got=%b exp=1", pr_we); else passed++;
        total++; if (pr_addr !== 32'h7F04) $display("FAIL dev_sw_addr got=%h exp=%h", pr_addr, 32'h7F04); else passed++;
        total++; if (pr_wdata !== 32'h0000_00C8) $display("FAIL dev_sw_wdata got=%h exp=%h", pr_wdata, 32'h0000_00C8); else passed++;
        drive(OP_SW, 32'h7F04, 32'h0000_00C8, 1'b1);
        total++; if ({pr_we, exc_code} !== 6'h0) $display("FAIL dev_sw_flush we=%b exc=%0d exp=0", pr_we, exc_code); else passed++;
        drive(OP_SW, 32'h7F08, 32'h1, 1'b0);
        total++; if (exc_code !== 5'd5 || pr_we !== 1'b0) $display("FAIL dev_count exc=%0d we=%b exp=5/0", exc_code, pr_we); else passed++;
        drive(OP_LB, 32'h7F10, 32'h0, 1'b0);
        total++; if (exc_code !== 5'd4) $display("FAIL dev_lb exc=%0d exp=4", exc_code); else passed++;
        drive(OP_SW, 32'h7F0C, 32'h0, 1'b0);
        total++; if (exc_code !== 5'd5) $display("FAIL dev_gap exc=%0d exp=5", exc_code); else passed++;
        pr_rdata = 32'hCAFE_BABE;
        drive(OP_LW, 32'h7F18, 32'h0, 1'b0);
        total++; if (rdata !== 32'hCAFE_BABE || exc_code !== 5'd0) $display("FAIL dev_lw rdata=%h exc=%0d exp=%h/0", rdata, exc_code, 32'hCAFE_BABE); else passed++;
        drive(OP_LW, 32'h7F12, 32'h0, 1'b0);
        total++; if (pr_addr !== 32'h7F10 || exc_code !== 5'd4) $display("FAIL dev_misalign addr=%h exc=%0d exp=%h/4", pr_addr, exc_code, 32'h7F10); else passed++;
        pr_rdata = 32'h0;
    endtask

    task automatic test_flush();
        drive(OP_SW, 32'h20, 32'hFFFF_FFFF, 1'b1);
        total++; if (exc_code !== 5'd0) $display("FAIL flush_exc exc=%0d exp=0", exc_code); else passed++;
        tick();
        drive(OP_LW, 32'h20, 32'h0, 1'b0);
        total++; if (rdata !== 32'h0) $display("FAIL flush_nowrite rdata=%h exp=%h", rdata, 32'h0); else passed++;
    endtask

    task automatic test_back_to_back();
        drive(OP_SW, 32'h24, 32'hA5A5_0F0F, 1'b0);
        @(posedge clk);
        #1;
        drive(OP_SB, 32'h27, 32'h0000_0011, 1'b0);
        total++; if (exc_code !== 5'd0) $display("FAIL b2b_sb_exc exc=%0d exp=0", exc_code); else passed++;
        @(posedge clk);
        #1;
        drive(OP_LW, 32'h24, 32'h0, 1'b0);
        total++; if (rdata !== 32'h11A5_0F0F) $display("FAIL b2b_lw rdata=%h exp=%h", rdata, 32'h11A5_0F0F); else passed++;
        drive(OP_LBU, 32'h26, 32'h0, 1'b0);
        total++; if (rdata !== 32'h0000_00A5) $display("FAIL b2b_lbu rdata=%h exp=%h", rdata, 32'h0000_00A5); else passed++;
    endtask

    task automatic test_reset_clear();
        reset = 1'b1;
        drive(OP_NONE, 32'h0, 32'h0, 1'b0);
        tick();
        reset = 1'b0;
        drive(OP_LW, 32'h10, 32'h0, 1'b0);
        total++; if (rdata !== 32'h0) $display("FAIL reset_clear_10 rdata=%h exp=%h", rdata, 32'h0); else passed++;
        drive(OP_LW, 32'h24, 32'h0, 1'b0);
        total++; if (rdata !== 32'h0) $display("FAIL reset_clear_24 rdata=%h exp=%h", rdata, 32'h0); else passed++;
    endtask

    initial begin
        reset    = 1'b1;
        pr_rdata = 32'h0;
        mem_op   = OP_NONE;
        addr     = 32'h0;
        wdata    = 32'h0;
        flush    = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_faults();
        test_device();
        test_flush();
        test_back_to_back();
        test_reset_clear();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
